// File: rtl/riscv_pkg.sv
// Shared widths and the result-source grant encoding for the writeback slice.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    // Which result source owns the write port.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. Request/grant bit 0 is the ALU, bit 1 is MEM.
// When both sources request, the one not granted last wins. The remembered
// winner only moves when the caller signals that the grant was actually used.
module rr_arbiter2
    import riscv_pkg::*;
(
    input  logic       stage_clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    grant_e last_grant;

    // One-hot grant from the current requests and the last winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == GRANT_ALU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Remember the winner of each accepted transfer; reset favours MEM next.
    always_ff @(posedge stage_clk) begin
        if (!reset) begin
            last_grant <= GRANT_ALU;
        end else if (advance && (gnt != 2'b00)) begin
            last_grant <= gnt[1] ? GRANT_MEM : GRANT_ALU;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: tracks pending destination registers (scoreboard), answers
// decode hazard queries, and funnels ALU / load results into one register
// bank write port, one result per cycle.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on anything but the offer, the scoreboard and
// the arbiter, and all readies are low while reset is held low.
module writeback_unit
    import riscv_pkg::*;
#(
    parameter int XLEN_P  = XLEN,
    parameter int NREGS_P = NREGS
) (
    input  logic              stage_clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    output logic              iss_ready,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN_P-1:0] alu_out,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN_P-1:0] data_in,
    output logic              mem_ready,
    output logic              wr_en,
    output logic [4:0]        rd,
    output logic [XLEN_P-1:0] wr_data,
    output logic              err
);

    logic [NREGS_P-1:0] busy;
    logic [NREGS_P-1:0] busy_n;
    logic [1:0]         gnt;
    logic               acc;
    logic [4:0]         acc_rd;
    logic [XLEN_P-1:0]  acc_data;
    logic               iss_fire;

    rr_arbiter2 u_arb (
        .stage_clk (stage_clk),
        .reset     (reset),
        .req       ({mem_valid, alu_valid}),
        .advance   (acc),
        .gnt       (gnt)
    );

    // Issue acceptance, hazard queries and result readies.
    always_comb begin
        iss_ready = reset && ((iss_rd == 5'd0) || !busy[iss_rd]);
        rs1_busy  = busy[rs1] && (rs1 != 5'd0);
        rs2_busy  = busy[rs2] && (rs2 != 5'd0);
        alu_ready = reset && gnt[0];
        mem_ready = reset && gnt[1];
        acc       = alu_ready || mem_ready;
        acc_rd    = mem_ready ? mem_rd  : alu_rd;
        acc_data  = mem_ready ? data_in : alu_out;
        iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);
    end

    // Next scoreboard: retire first, then issue, so a same-index issue wins.
    always_comb begin
        busy_n = busy;
        if (acc && (acc_rd != 5'd0)) begin
            busy_n[acc_rd] = 1'b0;
        end
        if (iss_fire) begin
            busy_n[iss_rd] = 1'b1;
        end
        busy_n[0] = 1'b0;
    end

    // Scoreboard, sticky error and the registered write port.
    always_ff @(posedge stage_clk) begin
        if (!reset) begin
            busy    <= '0;
            wr_en   <= 1'b0;
            rd      <= 5'd0;
            wr_data <= '0;
            err     <= 1'b0;
        end else begin
            busy  <= busy_n;
            wr_en <= acc && (acc_rd != 5'd0);
            if (acc && (acc_rd != 5'd0)) begin
                rd      <= acc_rd;
                wr_data <= acc_data;
                if (!busy[acc_rd]) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus random traffic, all
// checked each cycle against a behavioural model of the scoreboard,
// round-robin result selection and the one-cycle write port.
module tb_writeback_unit;

  logic        stage_clk;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_out;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] data_in;
  logic        mem_ready;
  logic        wr_en;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic        err;

  writeback_unit dut (
    .stage_clk (stage_clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_out   (alu_out),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .data_in   (data_in),
    .mem_ready (mem_ready),
    .wr_en     (wr_en),
    .rd        (rd),
    .wr_data   (wr_data),
    .err       (err)
  );

  // clock / reset
  initial stage_clk = 1'b0;
  always #5 stage_clk = ~stage_clk;

  // reference model state
  logic [31:0] m_busy;      // pending-write set, one bit per register
  logic        m_err;
  int          m_last;      // 0 = ALU granted last, 1 = MEM granted last
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_known;     // registered outputs defined (after first reset edge)
  logic [36:0] exp_q[$];    // {rd, data} writes expected on the next cycle

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at the falling edge, check everything, then advance the model.
  task automatic step(input logic rst, input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic av, input logic [4:0] ard, input logic [31:0] aout,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    logic        e_iss;
    int          g;
    logic [4:0]  w_rd;
    logic [31:0] w_dat;
    logic [36:0] e;
    @(negedge stage_clk);
    reset = rst; iss_valid = iv; iss_rd = ird; rs1 = r1; rs2 = r2;
    alu_valid = av; alu_rd = ard; alu_out = aout;
    mem_valid = mv; mem_rd = mrd; data_in = mdat;
    #1;
    e_iss = rst && ((ird == 5'd0) || !m_busy[ird]);
    g = -1;
    if (rst) begin
      if (av && mv)  g = (m_last == 0) ? 1 : 0;
      else if (av)   g = 0;
      else if (mv)   g = 1;
    end
    check("iss_ready", iss_ready, e_iss);
    check("alu_ready", alu_ready, g == 0);
    check("mem_ready", mem_ready, g == 1);
    if (m_known) begin
      check("rs1_busy", rs1_busy, (r1 != 5'd0) && m_busy[r1]);
      check("rs2_busy", rs2_busy, (r2 != 5'd0) && m_busy[r2]);
      check("err", err, m_err);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_rd = e[36:32];
        m_data = e[31:0];
        check("wr_en", wr_en, 1'b1);
      end else begin
        check("wr_en", wr_en, 1'b0);
      end
      check("rd", rd, m_rd);
      check("wr_data", wr_data, m_data);
    end
    // model update for the coming edge
    if (!rst) begin
      m_busy = '0; m_err = 1'b0; m_last = 0; m_rd = 5'd0; m_data = '0;
      exp_q.delete();
      m_known = 1'b1;
    end else begin
      if (g >= 0) begin
        m_last = g;
        w_rd  = (g == 1) ? mrd  : ard;
        w_dat = (g == 1) ? mdat : aout;
        if (w_rd != 5'd0) begin
          if (!m_busy[w_rd]) m_err = 1'b1;
          m_busy[w_rd] = 1'b0;
          exp_q.push_back({w_rd, w_dat});
        end
      end
      if (iv && e_iss && (ird != 5'd0)) m_busy[ird] = 1'b1;
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_busy = '0; m_err = 0; m_last = 0; m_rd = 0; m_data = 0; m_known = 0;
    reset = 0; iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_out = 0; mem_valid = 0; mem_rd = 0; data_in = 0;

    idle(0); idle(0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rd", rd, 5'd0);

    // issue rd=5, query, retire via ALU
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    check("d1_rs1_busy", rs1_busy, 1'b1);
    step(1, 0, 0, 5, 0, 1, 5, 32'h0000_000C, 0, 0, 0);
    step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    check("d1_wr_en", wr_en, 1'b1);
    check("d1_rd", rd, 5'd5);
    check("d1_wr_data", wr_data, 32'h0000_000C);
    check("d1_rs1_clear", rs1_busy, 1'b0);

    // WAW stall on rd=7 until its result is accepted
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d2_stall0", iss_ready, 1'b0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d2_stall1", iss_ready, 1'b0);
    step(1, 1, 7, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    check("d2_stall_acc", iss_ready, 1'b0);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d2_released", iss_ready, 1'b1);
    step(1, 0, 0, 0, 0, 1, 7, 32'h78, 0, 0, 0);
    idle(1);

    // contention: last grant was ALU, so MEM, ALU, MEM, ALU
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 2, 1, 1, 32'hA000 + i, 1, 2, 32'hB000 + i);
      check("d3_mem_grant", mem_ready, (i % 2) == 0);
      if (i > 0) check("d3_wr_pulse", wr_en, 1'b1);
    end
    idle(1);
    check("d3_last_pulse", wr_en, 1'b1);

    // rd=0 result is dropped; result to idle register raises sticky err
    idle(0);
    step(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    idle(1);
    check("d4_x0_wr_en", wr_en, 1'b0);
    check("d4_x0_err", err, 1'b0);
    step(1, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    idle(1);
    check("d4_err_set", err, 1'b1);
    idle(1); idle(1);
    check("d4_err_sticky", err, 1'b1);

    // reset right after an accepted load discards the pending write
    idle(0);
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h33);
    step(0, 1, 4, 3, 0, 1, 4, 32'h1, 1, 4, 32'h2);
    check("d5_iss_ready_rst", iss_ready, 1'b0);
    check("d5_alu_ready_rst", alu_ready, 1'b0);
    check("d5_mem_ready_rst", mem_ready, 1'b0);
    step(0, 1, 4, 3, 0, 1, 4, 32'h1, 1, 4, 32'h2);
    check("d5_no_wr", wr_en, 1'b0);
    check("d5_busy_clear", rs1_busy, 1'b0);
    idle(1);

    // random traffic on a small register window to provoke hazards
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(1); idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter NREGS, default 32, architectural register count; index width is log2(NREGS) = 5.
REQ-003 stage_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled only on the rising edge of stage_clk.
REQ-005 iss_valid  in  1  decode is issuing an instruction that writes iss_rd.
REQ-006 iss_rd  in  5  destination of the issuing instruction.
REQ-007 iss_ready  out  1  issue accepted this cycle.
REQ-008 rs1, rs2  in  5 each  decode hazard-query indices.
REQ-009 rs1_busy, rs2_busy  out  1 each  queried register has a pending write.
REQ-010 alu_valid, alu_rd, alu_out  in  1/5/XLEN  ALU result offer.
REQ-011 alu_ready  out  1  ALU result accepted this cycle.
REQ-012 mem_valid, mem_rd, data_in  in  1/5/XLEN  load-data result offer.
REQ-013 mem_ready  out  1  load result accepted this cycle.
REQ-014 wr_en, rd, wr_data  out  1/5/XLEN  write port toward the register bank.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 Scoreboard: busy[31:0] register; bit 0 SHALL always read 0.
REQ-017 iss_ready SHALL be combinational: 1 when iss_rd==0 or busy[iss_rd]==0 (WAW stall otherwise).
REQ-018 Issue handshake (iss_valid & iss_ready) with iss_rd!=0 SHALL set busy[iss_rd] at the next edge; iss_rd==0 sets nothing.
REQ-019 rsN_busy SHALL be combinational: busy[rsN] & (rsN!=0); no same-cycle bypass of an accepted result.
REQ-020 Arbitration: at most one result accepted per cycle; single valid source is granted; both valid -> round-robin via last_grant flag (grant the source not granted last); ready asserted only to the granted source.
REQ-021 last_grant SHALL update only on an accepted transfer.
REQ-022 Accepted result SHALL appear on wr_en/rd/wr_data registered, exactly 1 cycle after acceptance; wr_en high one cycle per accept; back-to-back accepts give back-to-back writes.
REQ-023 Accepted result with rd==0: wr_en SHALL stay 0, no scoreboard change, no err.
REQ-024 Accepted result with rd!=0 SHALL clear busy[rd] at the acceptance edge.
REQ-025 Accepted result to a register with busy[rd]==0 SHALL set err (sticky until reset); write still performed.
REQ-026 Simultaneous issue-set and result-clear of the same index: set wins (busy=1) and err is set per REQ-025.
REQ-027 When no transfer is accepted, wr_en SHALL be 0 next cycle; rd/wr_data hold their previous values.

Reset
REQ-028 reset==0 at an edge SHALL force busy=0, wr_en=0, rd=0, wr_data=0, err=0, last_grant=ALU, overriding all same-cycle handshakes.
REQ-029 While reset==0, iss_ready, alu_ready and mem_ready SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard pending writes; no wr_en pulse follows the first reset edge.

Structure
REQ-031 Shared package riscv_pkg holds XLEN, NREGS, REG_IDX_W=5, and the grant enum {GRANT_ALU, GRANT_MEM}.
REQ-032 Arbiter SHALL be a separate sub-module rr_arbiter2 (2 requests, one-hot grant, internal last_grant state, advance input).

Verification
REQ-033 Reset, issue rd=5 -> busy[5]=1, rs1=5 gives rs1_busy=1; alu_rd=5, alu_out=0x0000_000C accepted -> next cycle wr_en=1, rd=5, wr_data=0x0000_000C, busy[5]=0.
REQ-034 busy[7]=1, issue rd=7 -> iss_ready=0 until the rd=7 result is accepted, then iss_ready=1 the following cycle.
REQ-035 alu_valid and mem_valid held high 4 cycles (rd 1/2 busy) -> grants MEM,ALU,MEM,ALU; 4 consecutive wr_en pulses, no result lost.
REQ-036 alu_rd=0, alu_out=0xFFFF_FFFF accepted -> wr_en stays 0, busy unchanged, err=0; result to non-busy rd=9 -> err=1 and stays 1.
REQ-037 busy[3]=1, mem_valid accepted, reset=0 on the next edge -> wr_en=0, busy=0, all readies 0 while reset low.
